// File: rtl/lstm_seq_ctrl.sv
// LSTM inference sequencer: time-multiplexes one lstm_cell over TIMESTEPS samples, then reduces h through the FC layer.
// Optional build macro LSTM_STATE_PERSIST_EN keeps h/c across inferences (cleared only by rst_n).
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int UNITS        = 4,
  parameter int TIMESTEPS    = 2,
  parameter int CELL_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          x_valid,
  input  logic [DATA_WIDTH-1:0]         x_data,
  output logic                          x_ready,
  output logic [DATA_WIDTH-1:0]         cell_xt,
  output logic [UNITS*DATA_WIDTH-1:0]   cell_ht_prev,
  output logic [UNITS*DATA_WIDTH-1:0]   cell_ct_prev,
  input  logic [UNITS*DATA_WIDTH-1:0]   cell_ht,
  input  logic [UNITS*DATA_WIDTH-1:0]   cell_ct,
  input  logic [UNITS*DATA_WIDTH-1:0]   w_fc,
  input  logic [DATA_WIDTH-1:0]         b_fc,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         pred,
  output logic                          pred_valid
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_LOAD_X  | x_ready high, waiting for a sample
  // S_CELL_WAIT | lstm_cell settling, CELL_LATENCY cycles
  // S_CAPTURE | latch cell h/c, advance step
  // S_FC      | one FC unit per cycle into the accumulator
  // S_DONE    | add bias, saturate, publish pred

  localparam int DW     = DATA_WIDTH;
  localparam int ACC_W  = DW + $clog2(UNITS) + 1;
  localparam int STEP_W = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
  localparam int UNIT_W = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int WAIT_W = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;
  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((64'd1 << (DW - 1)) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_CELL_WAIT, S_CAPTURE, S_FC, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [STEP_W-1:0]      step;
  logic [UNIT_W-1:0]      unit;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [UNITS*DW-1:0]    h_reg, c_reg;
  logic [ACC_W-1:0]       acc;

  logic                   last_step, last_unit, wait_done;
  logic [DW-1:0]          h_sel, w_sel;
  logic [2*DW-1:0]        prod;
  logic [ACC_W-1:0]       term_mag, term, bias_mag, bias, sum, sum_mag;
  logic [DW-2:0]          clamped;
  logic [DW-1:0]          pred_nxt;

  assign last_step = (step == STEP_W'(TIMESTEPS - 1));
  assign last_unit = (unit == UNIT_W'(UNITS - 1));
  assign wait_done = (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_LOAD_X;
      S_LOAD_X:    if (x_valid) state_nxt = S_CELL_WAIT;
      S_CELL_WAIT: if (wait_done) state_nxt = S_CAPTURE;
      S_CAPTURE:   state_nxt = last_step ? S_FC : S_LOAD_X;
      S_FC:        if (last_unit) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    x_ready = (state == S_LOAD_X);
    busy    = (state != S_IDLE);
  end

  // sign-magnitude product, magnitude keeps bits [2W-1:W+1] of the full product
  always_comb begin
    h_sel    = h_reg[int'(unit)*DW +: DW];
    w_sel    = w_fc[int'(unit)*DW +: DW];
    prod     = {{(DW+1){1'b0}}, h_sel[DW-2:0]} * {{(DW+1){1'b0}}, w_sel[DW-2:0]};
    term_mag = ACC_W'(prod >> (DW + 1));
    term     = (h_sel[DW-1] ^ w_sel[DW-1]) ? -term_mag : term_mag;
    bias_mag = ACC_W'(b_fc[DW-2:0]);
    bias     = b_fc[DW-1] ? -bias_mag : bias_mag;
    sum      = acc + bias;
    sum_mag  = sum[ACC_W-1] ? -sum : sum;
    clamped  = (sum_mag > MAG_MAX) ? MAG_MAX[DW-2:0] : sum_mag[DW-2:0];
    pred_nxt = (clamped == '0) ? '0 : {sum[ACC_W-1], clamped};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step       <= '0;
      unit       <= '0;
      wait_cnt   <= '0;
      h_reg      <= '0;
      c_reg      <= '0;
      acc        <= '0;
      cell_xt    <= '0;
      pred       <= '0;
      pred_valid <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            step <= '0;
`ifdef LSTM_STATE_PERSIST_EN
            // stateful mode: h/c carry the previous inference's final state
`else
            h_reg <= '0;
            c_reg <= '0;
`endif
          end
        end
        S_LOAD_X: begin
          if (x_valid) begin
            cell_xt  <= x_data;
            wait_cnt <= WAIT_W'(CELL_LATENCY - 1);
          end
        end
        S_CELL_WAIT: begin
          if (!wait_done) wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        S_CAPTURE: begin
          h_reg <= cell_ht;
          c_reg <= cell_ct;
          step  <= step + STEP_W'(1);
          if (last_step) begin
            unit <= '0;
            acc  <= '0;
          end
        end
        S_FC: begin
          acc <= acc + term;
          if (!last_unit) unit <= unit + UNIT_W'(1);
        end
        S_DONE: begin
          pred       <= pred_nxt;
          pred_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cell_ht_prev = h_reg;
  assign cell_ct_prev = c_reg;

endmodule
